// File: rtl/div_radix_param_pkg.sv
// Shared opcode encodings, FSM state type and opcode decode helpers for the
// iterative RV32M divider.
package div_radix_param_pkg;

    // funct3 encodings of the M-extension divide group
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Anything outside the divide group falls back to DIVU.
    function automatic logic [2:0] op_normalise(input logic [2:0] op);
        if (op == OP_DIV || op == OP_REM || op == OP_REMU) begin
            return op;
        end
        return OP_DIVU;
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_radix_step.sv
// One restoring division step: shift one dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module div_radix_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    assign shifted = {rem_in, bit_in};
    // Compare at XLEN+1 bits; the true difference always fits in XLEN bits.
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign diff    = shifted[XLEN-1:0] - divisor;
    assign rem_out = q_bit ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/div_radix_param.sv
// Iterative DIV/DIVU/REM/REMU unit retiring BITS_PER_CYCLE quotient bits per
// cycle, with a valid/ready result handshake and a pipeline flush abort.
module div_radix_param
    import div_radix_param_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  div_req_i,
    input  logic [XLEN-1:0]       div_data1_i,
    input  logic [XLEN-1:0]       div_data2_i,
    input  logic [2:0]            div_op_code_i,
    input  logic [REG_ADDR_W-1:0] div_reg_wr_addr_i,
    input  logic                  div_flush_i,
    input  logic                  div_res_ready_i,
    output logic                  div_busy_o,
    output logic                  div_res_valid_o,
    output logic [XLEN-1:0]       div_res_o,
    output logic [REG_ADDR_W-1:0] div_reg_wr_addr_o
);

    localparam int ITER  = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITER + 1);

    div_state_e        state;
    logic [XLEN-1:0]   acc_hi;      // partial remainder
    logic [XLEN-1:0]   acc_lo;      // dividend bits out, quotient bits in
    logic [XLEN-1:0]   divisor_q;
    logic [CNT_W-1:0]  cnt;
    logic              is_rem_q;
    logic              neg_quo_q;
    logic              neg_rem_q;

    // Request decode, evaluated only when a request is taken in IDLE.
    logic [2:0]      op_n;
    logic            op_signed;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            ovf;

    assign op_n      = op_normalise(div_op_code_i);
    assign op_signed = op_is_signed(op_n);
    assign op_rem    = op_is_rem(op_n);
    assign a_neg     = op_signed & div_data1_i[XLEN-1];
    assign b_neg     = op_signed & div_data2_i[XLEN-1];
    assign abs_a     = a_neg ? -div_data1_i : div_data1_i;
    assign abs_b     = b_neg ? -div_data2_i : div_data2_i;
    assign div_zero  = (div_data2_i == '0);
    assign ovf       = op_signed && (div_data1_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (div_data2_i == '1);

    // Chain of restoring steps evaluated in one cycle; step 0 takes the MSB.
    logic [XLEN-1:0]           rem_chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] q_vec;
    logic [XLEN-1:0]           next_hi;
    logic [XLEN-1:0]           next_lo;
    logic [XLEN-1:0]           fixed_res;

    assign rem_chain[0] = acc_hi;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        div_radix_step #(
            .XLEN(XLEN)
        ) u_step (
            .rem_in (rem_chain[g]),
            .bit_in (acc_lo[XLEN-1-g]),
            .divisor(divisor_q),
            .rem_out(rem_chain[g+1]),
            .q_bit  (q_vec[BITS_PER_CYCLE-1-g])
        );
    end

    assign next_hi = rem_chain[BITS_PER_CYCLE];
    assign next_lo = {acc_lo[XLEN-1-BITS_PER_CYCLE:0], q_vec};

    // Sign fix applied on the final iteration as the result is registered.
    always_comb begin
        fixed_res = '0;
        if (is_rem_q) begin
            fixed_res = neg_rem_q ? -next_hi : next_hi;
        end else begin
            fixed_res = neg_quo_q ? -next_lo : next_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            acc_hi            <= '0;
            acc_lo            <= '0;
            divisor_q         <= '0;
            cnt               <= '0;
            is_rem_q          <= 1'b0;
            neg_quo_q         <= 1'b0;
            neg_rem_q         <= 1'b0;
            div_busy_o        <= 1'b0;
            div_res_valid_o   <= 1'b0;
            div_res_o         <= '0;
            div_reg_wr_addr_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (div_req_i && !div_flush_i) begin
                        div_busy_o        <= 1'b1;
                        div_reg_wr_addr_o <= div_reg_wr_addr_i;
                        is_rem_q          <= op_rem;
                        neg_quo_q         <= a_neg ^ b_neg;
                        neg_rem_q         <= a_neg;
                        if (div_zero) begin
                            div_res_o       <= op_rem ? div_data1_i : '1;
                            div_res_valid_o <= 1'b1;
                            state           <= ST_DONE;
                        end else if (ovf) begin
                            div_res_o       <= op_rem ? '0 : div_data1_i;
                            div_res_valid_o <= 1'b1;
                            state           <= ST_DONE;
                        end else begin
                            acc_hi    <= '0;
                            acc_lo    <= abs_a;
                            divisor_q <= abs_b;
                            cnt       <= '0;
                            state     <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (div_flush_i) begin
                        div_busy_o      <= 1'b0;
                        div_res_valid_o <= 1'b0;
                        div_res_o       <= '0;
                        state           <= ST_IDLE;
                    end else begin
                        acc_hi <= next_hi;
                        acc_lo <= next_lo;
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(ITER - 1)) begin
                            div_res_o       <= fixed_res;
                            div_res_valid_o <= 1'b1;
                            state           <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Flush and a consumer accept both retire the slot.
                    if (div_flush_i || div_res_ready_i) begin
                        div_busy_o      <= 1'b0;
                        div_res_valid_o <= 1'b0;
                        div_res_o       <= '0;
                        state           <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix_param.sv
// Directed bench for div_radix_param: a radix-2 instance and a radix-16
// instance share operand/handshake inputs and have separate request lines.
module tb_div_radix_param;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        req_a;
    logic        req_b;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [2:0]  op;
    logic [4:0]  addr_in;
    logic        flush;
    logic        ready;

    logic        busy_a;
    logic        valid_a;
    logic [31:0] res_a;
    logic [4:0]  addr_a;
    logic        busy_b;
    logic        valid_b;
    logic [31:0] res_b;
    logic [4:0]  addr_b;

    int total;
    int bad;

    div_radix_param #(
        .XLEN(32), .BITS_PER_CYCLE(1), .REG_ADDR_W(5)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .div_req_i(req_a),
        .div_data1_i(data1), .div_data2_i(data2), .div_op_code_i(op),
        .div_reg_wr_addr_i(addr_in), .div_flush_i(flush),
        .div_res_ready_i(ready), .div_busy_o(busy_a),
        .div_res_valid_o(valid_a), .div_res_o(res_a),
        .div_reg_wr_addr_o(addr_a)
    );

    div_radix_param #(
        .XLEN(32), .BITS_PER_CYCLE(4), .REG_ADDR_W(5)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .div_req_i(req_b),
        .div_data1_i(data1), .div_data2_i(data2), .div_op_code_i(op),
        .div_reg_wr_addr_i(addr_in), .div_flush_i(flush),
        .div_res_ready_i(ready), .div_busy_o(busy_b),
        .div_res_valid_o(valid_b), .div_res_o(res_b),
        .div_reg_wr_addr_o(addr_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // One operation with ready held high; checks latency, result, address
    // and retirement on the following edge.
    task automatic run_op(input bit sel_b, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input logic [31:0] exp,
                          input int exp_lat, input string name);
        int lat;
        @(negedge clk);
        op = o; data1 = a; data2 = b; addr_in = wa; ready = 1'b1;
        if (sel_b) req_b = 1'b1; else req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        lat = 1;
        while (!(sel_b ? valid_b : valid_a) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
        end
        total++;
        if ((sel_b ? res_b : res_a) !== exp) begin
            bad++;
            $display("FAIL %s result got=%h want=%h", name, sel_b ? res_b : res_a, exp);
        end
        total++;
        if ((sel_b ? addr_b : addr_a) !== wa) begin
            bad++;
            $display("FAIL %s addr got=%0d want=%0d", name, sel_b ? addr_b : addr_a, wa);
        end
        @(posedge clk); #1;
        total++;
        if ((sel_b ? busy_b : busy_a) !== 1'b0 || (sel_b ? valid_b : valid_a) !== 1'b0
            || (sel_b ? res_b : res_a) !== 32'h0) begin
            bad++;
            $display("FAIL %s retire busy=%b valid=%b res=%h want 0/0/0", name,
                     sel_b ? busy_b : busy_a, sel_b ? valid_b : valid_a,
                     sel_b ? res_b : res_a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; flush = 1'b0; ready = 1'b0;
        data1 = 32'h0; data2 = 32'h0; op = OP_DIVU; addr_in = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy_a, valid_a, res_a, addr_a} !== 39'h0) begin
            bad++;
            $display("FAIL reset_a busy=%b valid=%b res=%h addr=%0d want all 0",
                     busy_a, valid_a, res_a, addr_a);
        end
        total++;
        if ({busy_b, valid_b, res_b, addr_b} !== 39'h0) begin
            bad++;
            $display("FAIL reset_b busy=%b valid=%b res=%h addr=%0d want all 0",
                     busy_b, valid_b, res_b, addr_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        run_op(0, OP_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 33, "divu_100_7");
        run_op(0, OP_REMU, 32'd100, 32'd7, 5'd2, 32'd2, 33, "remu_100_7");
        run_op(0, OP_DIVU, 32'hFFFFFFFF, 32'd10, 5'd3, 32'h19999999, 33, "divu_max_10");
        run_op(0, OP_REMU, 32'hFFFFFFFF, 32'd10, 5'd4, 32'd5, 33, "remu_max_10");
        run_op(0, 3'b000, 32'd100, 32'd7, 5'd5, 32'd14, 33, "unknown_op_as_divu");
    endtask

    task automatic test_signed();
        run_op(0, OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 33, "div_m7_2");
        run_op(0, OP_REM, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, 33, "rem_m7_2");
        run_op(0, OP_DIV, 32'd7, 32'hFFFFFFFE, 5'd8, 32'hFFFFFFFD, 33, "div_7_m2");
        run_op(0, OP_REM, 32'd7, 32'hFFFFFFFE, 5'd9, 32'd1, 33, "rem_7_m2");
    endtask

    task automatic test_special();
        run_op(0, OP_DIV, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 1, "div_by_zero");
        run_op(0, OP_REMU, 32'h1234, 32'd0, 5'd11, 32'h1234, 1, "remu_by_zero");
        run_op(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1, "div_overflow");
        run_op(0, OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h0, 1, "rem_overflow");
        run_op(1, OP_DIVU, 32'd9, 32'd0, 5'd14, 32'hFFFFFFFF, 1, "r16_divu_by_zero");
    endtask

    task automatic test_radix16();
        run_op(1, OP_DIVU, 32'd100, 32'd7, 5'd15, 32'd14, 9, "r16_divu_100_7");
        run_op(1, OP_DIV, 32'hFFFFFF9C, 32'd7, 5'd16, 32'hFFFFFFF2, 9, "r16_div_m100_7");
        run_op(1, OP_REM, 32'hFFFFFF9C, 32'd7, 5'd17, 32'hFFFFFFFE, 9, "r16_rem_m100_7");
        run_op(1, OP_REMU, 32'hDEADBEEF, 32'h10, 5'd18, 32'hF, 9, "r16_remu_beef");
        run_op(1, OP_DIVU, 32'hDEADBEEF, 32'h10, 5'd19, 32'h0DEADBEE, 9, "r16_divu_beef");
        run_op(1, OP_DIV, 32'hFFFFFFFF, 32'd1, 5'd20, 32'hFFFFFFFF, 9, "r16_div_m1_1");
        run_op(1, OP_DIV, 32'h80000000, 32'd2, 5'd21, 32'hC0000000, 9, "r16_div_min_2");
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        op = OP_DIVU; data1 = 32'd50; data2 = 32'd6; addr_in = 5'd17;
        ready = 1'b0; req_b = 1'b1;
        @(posedge clk); #1;
        req_b = 1'b0;
        lat = 1;
        while (!valid_b && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== 9) begin
            bad++;
            $display("FAIL hold latency got=%0d want=9", lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_b = 1'b1; data1 = 32'd9; data2 = 32'd3; addr_in = 5'd3;
            @(posedge clk); #1;
            total++;
            if (valid_b !== 1'b1 || res_b !== 32'd8 || addr_b !== 5'd17 || busy_b !== 1'b1) begin
                bad++;
                $display("FAIL hold cycle %0d valid=%b res=%h addr=%0d busy=%b want 1/8/17/1",
                         i, valid_b, res_b, addr_b, busy_b);
            end
        end
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (valid_b !== 1'b0 || busy_b !== 1'b0 || res_b !== 32'h0) begin
            bad++;
            $display("FAIL hold retire valid=%b busy=%b res=%h want 0/0/0", valid_b, busy_b, res_b);
        end
        @(posedge clk); #1;
        req_b = 1'b0;
        total++;
        if (busy_b !== 1'b1) begin
            bad++;
            $display("FAIL next accept busy=%b want 1", busy_b);
        end
        lat = 1;
        while (!valid_b && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (res_b !== 32'd3 || addr_b !== 5'd3 || lat !== 9) begin
            bad++;
            $display("FAIL next result res=%h addr=%0d lat=%0d want 3/3/9", res_b, addr_b, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        op = OP_DIVU; data1 = 32'd1000; data2 = 32'd3; addr_in = 5'd9;
        ready = 1'b1; req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || res_a !== 32'h0) begin
            bad++;
            $display("FAIL flush_calc busy=%b valid=%b res=%h want 0/0/0", busy_a, valid_a, res_a);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_a || busy_a) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL flush_no_result active_cycles=%0d want 0", seen);
        end
        @(negedge clk);
        flush = 1'b1; req_a = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req_a = 1'b0;
        total++;
        if (busy_a !== 1'b0) begin
            bad++;
            $display("FAIL flush_over_req busy=%b want 0", busy_a);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        op = OP_DIVU; data1 = 32'd1000; data2 = 32'd3; addr_in = 5'd21;
        ready = 1'b1; req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || res_a !== 32'h0 || addr_a !== 5'd0) begin
            bad++;
            $display("FAIL async_reset busy=%b valid=%b res=%h addr=%0d want all 0",
                     busy_a, valid_a, res_a, addr_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, OP_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33, "after_reset_divu_9_3");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_radix16();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_radix_param.md
Name: div_radix_param

Overview:
- Parametrised iterative integer divider for the RV32M execute stage. It executes DIV/DIVU/REM/REMU.
- Generalised in operand width (XLEN) and in quotient bits retired per cycle (radix 2^BITS_PER_CYCLE).
- Adds a valid/ready result handshake with output holding, a pipeline-flush abort, and single-cycle resolution of the RISC-V special cases (divide-by-zero, signed overflow).
- Sits beside the ALU in ex. The hazard logic stalls on div_busy_o, and the regfile write mux consumes the result.

Parameters:
XLEN, 32, operand and result width; power of two, 8..64
BITS_PER_CYCLE, 1, quotient bits per iteration; 1, 2 or 4; must divide XLEN
REG_ADDR_W, 5, destination register address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
div_req_i  in  1  start request; accepted only when div_busy_o=0
div_data1_i  in  XLEN  dividend (rs1)
div_data2_i  in  XLEN  divisor (rs2)
div_op_code_i  in  3  `DIV/`DIVU/`REM/`REMU (funct3 from defines.v)
div_reg_wr_addr_i  in  REG_ADDR_W  destination register
div_flush_i  in  1  abort in-flight operation (branch/trap flush)
div_res_ready_i  in  1  consumer accepts result
div_busy_o  out  1  operation accepted and not yet retired
div_res_valid_o  out  1  result valid; held until ready
div_res_o  out  XLEN  quotient or remainder
div_reg_wr_addr_o  out  REG_ADDR_W  destination register of the result

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - All outputs go to 0 and the state goes to IDLE.
  - Internal dividend/divisor/quotient registers and the counter go to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On div_req_i=1 (and no flush), latch the opcode, the address, and the operand signs.
  - Signed ops use absolute values; unsigned ops pass through.
  - div_busy_o is 1 from the next edge.
  - If divisor==0: result = all-ones for DIV/DIVU, dividend for REM/REMU; go to DONE.
  - Else if signed op, dividend = 1<<(XLEN-1) and divisor = all-ones (overflow): result = dividend for DIV, 0 for REM; go to DONE.
  - Otherwise go to CALC with counter=0.
  - An unknown opcode is treated as DIVU.
- CALC:
  - Each cycle performs BITS_PER_CYCLE chained restoring shift/compare/subtract steps, all combinational within the cycle.
  - The counter increments per cycle; after XLEN/BITS_PER_CYCLE cycles, go to DONE.
  - Sign fix on entry to DONE:
    - Quotient is negated if the signs differ (DIV).
    - Remainder takes the dividend sign (REM).
- Latency, from the accepting edge to the edge that raises div_res_valid_o:
  - Normal ops: XLEN/BITS_PER_CYCLE + 1 edges, i.e. 33 at the defaults, 9 for 32/4.
  - Special cases: 1 edge.
- DONE:
  - div_res_valid_o=1; div_res_o and div_reg_wr_addr_o are stable.
  - On div_res_ready_i=1, at that edge: div_res_valid_o goes to 0, div_busy_o to 0, state to IDLE.
  - If ready is already high in the first DONE cycle, the result retires in one cycle.
- div_req_i while busy is ignored; the upstream stalls on div_busy_o.
  - A new request is accepted only in IDLE, so it is accepted no earlier than the edge after retirement.
- div_flush_i=1 in CALC or DONE:
  - Next state IDLE; div_busy_o, div_res_valid_o and div_res_o go to 0.
  - No result is produced.
- Flush has priority over req in IDLE (the request is dropped) and over ready in DONE.
- div_res_o reads 0 whenever div_res_valid_o=0.
- Widths:
  - Internal remainder/dividend register is 2*XLEN bits.
  - Compare is done at XLEN+1 bits to avoid overflow.
  - Negation is two's complement modulo 2^XLEN.

Decomposition:
- Opcode codes `DIV/`DIVU/`REM/`REMU, `ZERO_WORD, and the state encodings go in the shared defines.v.
- One natural sub-module: div_radix_step.
  - Combinational, parametrised by XLEN.
  - One restoring step: partial remainder and divisor in; next partial remainder and quotient bit out.
  - The top instantiates it BITS_PER_CYCLE times in a generate chain.

Test Plan:
1. Defaults, DIVU 100/7 with ready held high → valid after 33 edges; res=14. REMU on the same operands → 2.
2. DIV -7/2 → -3 (0xFFFFFFFD). REM -7/2 → -1. DIV 7/-2 → -3. REM 7/-2 → 1.
3. DIV x/0 → 0xFFFFFFFF. REMU 0x1234/0 → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0. Each valid after 1 edge.
4. BITS_PER_CYCLE=4, random 1000 ops across all opcodes against a reference model → match; latency is 9 edges.
5. Hold div_res_ready_i=0 for 5 cycles in DONE → valid, result and address are stable. A concurrent div_req_i is ignored. Raise ready → retire; the next request is accepted.
6. Assert div_flush_i at CALC cycle 10 → IDLE, busy=0, no valid. Assert rst_n=0 mid-CALC → all outputs 0 asynchronously. A following DIVU 9/3 → 3.
